// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the adder back end: field widths, exponent
// limits, the normalize/round FSM states and the word packing helper.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SIG_W  = 11;

    localparam logic [EXP_W-1:0] EXP_MAX      = 5'h1F;
    localparam logic [EXP_W-1:0] EXP_MIN_NORM = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [EXP_W+FRAC_W:0] fp16_pack(
        input logic             s,
        input logic [EXP_W-1:0] e,
        input logic [FRAC_W-1:0] f
    );
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round step: optional increment, carry-out renormalize, flag
// derivation and binary16 packing of the normalized significand.
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic [SIG_W-1:0]       mant,
    input  logic [EXP_W:0]         exp_in,
    input  logic                   sign,
    input  logic                   rnd,
    input  logic                   sticky,
    input  logic                   ovf_in,
    input  logic                   den_in,
    input  logic                   zero_in,
    input  logic                   shifted_in,
    output logic [EXP_W+FRAC_W:0]  result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);

    logic [SIG_W:0]   sum_s;
    logic [SIG_W-1:0] mant_s;
    logic [EXP_W:0]   exp_s;
    logic             ovf_s;
    logic             den_s;

    // Increment, renormalize on carry-out, then pack and flag.
    always_comb begin
        sum_s  = {1'b0, mant} + {11'd0, (rnd & sticky & ~ovf_in)};
        mant_s = sum_s[SIG_W-1:0];
        exp_s  = exp_in;
        ovf_s  = ovf_in;
        den_s  = den_in;

        if (sum_s[SIG_W]) begin
            mant_s = 11'h400;
            exp_s  = exp_in + 6'd1;
        end else begin
            mant_s = sum_s[SIG_W-1:0];
        end

        if (exp_s >= 6'd31) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = ovf_in;
        end

        // A subnormal rounded into the hidden bit is the smallest normal (exp 1).
        if (den_in && mant_s[SIG_W-1]) begin
            den_s = 1'b0;
        end else begin
            den_s = den_in;
        end

        if (ovf_s) begin
            result = fp16_pack(sign, EXP_MAX, 10'h000);
        end else if (den_s || zero_in) begin
            result = fp16_pack(sign, 5'h00, mant_s[FRAC_W-1:0]);
        end else begin
            result = fp16_pack(sign, exp_s[EXP_W-1:0], mant_s[FRAC_W-1:0]);
        end

        overflow  = ovf_s;
        underflow = den_s | (zero_in & shifted_in);
        inexact   = sticky | ovf_s;
    end

endmodule

// File: rtl/normalize_pack.sv
// Sequential normalize/round/pack back end of the binary16 adder: shifts left
// one bit per cycle, rounds once, and presents the packed word on valid/ready.
module normalize_pack
    import fp16_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIG_W-1:0]      mant,
    input  logic                  exp_inc,
    input  logic                  sticky,
    input  logic [EXP_W-1:0]      exp,
    input  logic                  sign,
    input  logic                  rnd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);

    state_e            state_q, state_d;
    logic [SIG_W-1:0]  mant_q, mant_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              rnd_q, rnd_d;
    logic              sticky_q, sticky_d;
    logic              ovf_q, ovf_d;
    logic              den_q, den_d;
    logic              zero_q, zero_d;
    logic              shifted_q, shifted_d;
    logic [15:0]       result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              inexact_q, inexact_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [EXP_W-1:0]  exp_floor_s;
    logic [15:0]       rp_result_s;
    logic              rp_overflow_s;
    logic              rp_underflow_s;
    logic              rp_inexact_s;

    fp16_round_pack u_round_pack (
        .mant       (mant_q),
        .exp_in     (exp_q),
        .sign       (sign_q),
        .rnd        (rnd_q),
        .sticky     (sticky_q),
        .ovf_in     (ovf_q),
        .den_in     (den_q),
        .zero_in    (zero_q),
        .shifted_in (shifted_q),
        .result     (rp_result_s),
        .overflow   (rp_overflow_s),
        .underflow  (rp_underflow_s),
        .inexact    (rp_inexact_s)
    );

    // Next-state and datapath updates for the four-state normalize/round FSM.
    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        rnd_d       = rnd_q;
        sticky_d    = sticky_q;
        ovf_d       = ovf_q;
        den_d       = den_q;
        zero_d      = zero_q;
        shifted_d   = shifted_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        exp_floor_s = (exp == 5'd0) ? EXP_MIN_NORM : exp;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_d    = mant;
                    sticky_d  = sticky;
                    sign_d    = sign;
                    rnd_d     = rnd;
                    exp_d     = {1'b0, exp_floor_s} + {5'd0, exp_inc};
                    ovf_d     = 1'b0;
                    den_d     = 1'b0;
                    zero_d    = 1'b0;
                    shifted_d = 1'b0;
                    state_d   = ST_NORM;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (exp_q >= 6'd31) begin
                    ovf_d   = 1'b1;
                    state_d = ST_ROUND;
                end else if (mant_q == 11'h000) begin
                    zero_d  = 1'b1;
                    state_d = ST_ROUND;
                end else if (mant_q[SIG_W-1]) begin
                    state_d = ST_ROUND;
                end else if (exp_q == 6'd1) begin
                    den_d   = 1'b1;
                    state_d = ST_ROUND;
                end else begin
                    mant_d    = {mant_q[SIG_W-2:0], 1'b0};
                    exp_d     = exp_q - 6'd1;
                    shifted_d = 1'b1;
                    state_d   = ST_NORM;
                end
            end
            ST_ROUND: begin
                result_d    = rp_result_s;
                overflow_d  = rp_overflow_s;
                underflow_d = rp_underflow_s;
                inexact_d   = rp_inexact_s;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers; synchronous reset drops any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mant_q      <= 11'h000;
            exp_q       <= 6'd0;
            sign_q      <= 1'b0;
            rnd_q       <= 1'b0;
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
            den_q       <= 1'b0;
            zero_q      <= 1'b0;
            shifted_q   <= 1'b0;
            result_q    <= 16'h0000;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            rnd_q       <= rnd_d;
            sticky_q    <= sticky_d;
            ovf_q       <= ovf_d;
            den_q       <= den_d;
            zero_q      <= zero_d;
            shifted_q   <= shifted_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_normalize_pack.sv
// Directed self-checking bench for normalize_pack: hand-computed binary16
// results, flags, latency, backpressure and mid-flight reset.
module tb_normalize_pack;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] mant;
    logic        exp_inc;
    logic        sticky;
    logic [4:0]  exp;
    logic        sign;
    logic        rnd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int n_checks;
    int n_fail;

    normalize_pack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant      (mant),
        .exp_inc   (exp_inc),
        .sticky    (sticky),
        .exp       (exp),
        .sign      (sign),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: offers one bundle from IDLE and waits (bounded) for out_valid.
    task automatic run_txn(input logic [10:0] m, input logic [4:0] e, input logic ei,
                           input logic st, input logic sg, input logic rd, output int lat);
        mant = m; exp = e; exp_inc = ei; sticky = st; sign = sg; rnd = rd;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mant = 11'h5A5; exp = 5'd7;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (result !== 16'h0000 || {overflow, underflow, inexact} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h flags=%b required 0000 000",
                     result, {overflow, underflow, inexact});
        end
    endtask

    task automatic check_txn(input string name, input int lat, input int exp_lat,
                             input logic [15:0] exp_res, input logic [2:0] exp_flags);
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (result !== exp_res) begin
            n_fail++;
            $display("FAIL %s_result: got %h required %h", name, result, exp_res);
        end
        n_checks++;
        if ({overflow, underflow, inexact} !== exp_flags) begin
            n_fail++;
            $display("FAIL %s_flags: got %b required %b", name, {overflow, underflow, inexact}, exp_flags);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_txn(11'h400, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check_txn("basic", lat, 2, 16'h3C00, 3'b000);
        handoff();
        run_txn(11'h400, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check_txn("exp_zero", lat, 2, 16'h0400, 3'b000);
        handoff();
    endtask

    task automatic test_shift();
        int lat;
        run_txn(11'h100, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check_txn("shift2", lat, 4, 16'h3400, 3'b000);
        handoff();
    endtask

    task automatic test_round();
        int lat;
        run_txn(11'h7FF, 5'd15, 1'b0, 1'b1, 1'b0, 1'b1, lat);
        check_txn("round_carry", lat, 2, 16'h4000, 3'b001);
        handoff();
        run_txn(11'h7FF, 5'd15, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check_txn("truncate", lat, 2, 16'h3FFF, 3'b001);
        handoff();
    endtask

    task automatic test_overflow();
        int lat;
        run_txn(11'h400, 5'd30, 1'b1, 1'b0, 1'b1, 1'b0, lat);
        check_txn("ovf_inc", lat, 2, 16'hFC00, 3'b101);
        handoff();
        run_txn(11'h7FF, 5'd30, 1'b0, 1'b1, 1'b0, 1'b1, lat);
        check_txn("ovf_round", lat, 2, 16'h7C00, 3'b101);
        handoff();
    endtask

    task automatic test_denormal();
        int lat;
        run_txn(11'h001, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, lat);
        check_txn("denorm", lat, 4, 16'h8004, 3'b010);
        handoff();
        run_txn(11'h000, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check_txn("zero", lat, 2, 16'h0000, 3'b000);
        handoff();
        run_txn(11'h3FF, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, lat);
        check_txn("denorm_to_norm", lat, 2, 16'h0400, 3'b001);
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        run_txn(11'h400, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        mant = 11'h123; exp = 5'd9; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || result !== 16'h3C00 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: out_valid=%b result=%h in_ready=%b required 1 3c00 0",
                         i, out_valid, result, in_ready);
            end
        end
        in_valid = 1'b0;
        handoff();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_handoff: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        run_txn(11'h100, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check_txn("after_hold", lat, 4, 16'h3400, 3'b000);
        handoff();
    endtask

    task automatic test_reset_midflight();
        int lat;
        mant = 11'h001; exp = 5'd20; exp_inc = 1'b0; sticky = 1'b0; sign = 1'b0; rnd = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_in_ready: got %b required 0", in_ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        run_txn(11'h400, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        check_txn("post_reset", lat, 2, 16'h3C00, 3'b000);
        handoff();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mant = 11'h000; exp = 5'd0; exp_inc = 1'b0; sticky = 1'b0; sign = 1'b0; rnd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_shift();
        test_round();
        test_overflow();
        test_denormal();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/normalize_pack.md
# normalize_pack

Sequential back end of the half-precision adder datapath. Consumes the raw mantissa result, carry-adjust flag and sticky bit produced by the mantissa add/subtract stage, together with the larger operand's exponent and the result sign. Normalizes left one bit per cycle, applies the selected rounding, and packs an IEEE 754 binary16 word. The result is handed off through a valid/ready pair.

## Interface

- No parameters; widths fixed to binary16 (5-bit exponent, 10-bit fraction, 11-bit significand with hidden bit).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept; high only in IDLE.
- mant  in  11  significand; hidden bit at [10].
- exp_inc  in  1  mantissa already shifted right once; exponent must be incremented.
- sticky  in  1  nonzero bits lost below mant[0].
- exp  in  5  larger operand exponent, valid range 1..30; 0 is treated as 1.
- sign  in  1  result sign.
- rnd  in  1  0 = truncate; 1 = round magnitude up when sticky.
- out_valid  out  1  result held valid until taken.
- out_ready  in  1  downstream accepts.
- result  out  16  packed binary16 {sign, exp[4:0], frac[9:0]}.
- overflow  out  1  result forced to infinity.
- underflow  out  1  result is subnormal or zero after a left shift.
- inexact  out  1  sticky was set or rounding altered the value.

## Operation

- FSM states: IDLE, NORM, ROUND, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid, register mant, sticky, sign and rnd; set exp_r = max(exp,1) + exp_inc (6-bit add); go to NORM.
- **NORM** (evaluated once per cycle)
  - If exp_r ≥ 31: go to ROUND with the overflow flag set.
  - Else if mant_r == 0: go to ROUND; result is signed zero with exponent field 0.
  - Else if mant_r[10] == 1: go to ROUND.
  - Else if exp_r == 1: go to ROUND with the denormal flag set.
  - Else: mant_r <<= 1, exp_r -= 1; stay in NORM.
- **ROUND**
  - If rnd && sticky && !overflow: mant_r += 1.
  - If the sum is 0x800: mant_r = 0x400, exp_r += 1.
  - If exp_r then reaches 31, set overflow.
  - A denormal whose mant_r reaches 0x400 becomes normal with exponent 1 and underflow clear.
  - Pack the result:
    - Overflow: {sign, 5'h1F, 10'h000}.
    - Denormal: {sign, 5'h00, mant_r[9:0]}.
    - Otherwise: {sign, exp_r[4:0], mant_r[9:0]}.
  - Compute flags, register them with result, go to DONE.
- **DONE**
  - out_valid=1; result and flags stable.
  - On out_ready, go to IDLE.
- Flags:
  - inexact = sticky | overflow.
  - underflow = denormal flag, or a zero result reached through at least one shift.

## Timing

- Reset values: state IDLE, in_ready=1, out_valid=0, result=16'h0000, overflow=0, underflow=0, inexact=0.
- Latency: acceptance edge at cycle 0; out_valid rises at cycle k+2, where k is the number of left shifts (0..10). Maximum latency is 12.
- One transaction in flight at a time.
  - in_ready=0 from the acceptance edge until the DONE→IDLE edge.
  - No new input is accepted in the same cycle as the handoff; IDLE is visited for at least one cycle.
- out_valid must not drop, and result must not change, while out_ready=0.
- in_valid while in_ready=0 is ignored; inputs are not sampled.
- reset in any state returns to IDLE on that edge and discards the transaction; out_valid=0 on the next cycle.

## Structure

- Shared package `fp16_pkg`:
  - Widths: EXP_W=5, FRAC_W=10, SIG_W=11.
  - Constants: EXP_MAX=5'h1F, EXP_MIN_NORM=1.
  - The FSM state enum.
  - A pack function producing {sign, exp, frac}.
- Natural sub-module `fp16_round_pack`: combinational increment, carry-out renormalize, and pack used by ROUND.
- Normalization loop and FSM live in the top module.

## Test plan

- mant=0x400, exp=15, sign=0, exp_inc=0, sticky=0 → result 0x3C00, flags 0, out_valid at cycle 2.
- mant=0x100, exp=15 → 2 shifts, result 0x3400, out_valid at cycle 4, flags 0.
- mant=0x7FF, exp=15, sticky=1, rnd=1 → carry renormalize, result 0x4000, inexact=1; same inputs with rnd=0 → 0x3FFF, inexact=1.
- mant=0x400, exp=30, exp_inc=1, sign=1 → 0xFC00, overflow=1, inexact=1.
- mant=0x001, exp=3, sign=1 → 2 shifts, result 0x8004, underflow=1; mant=0x000 → 0x0000, underflow=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0.
  - Assert reset during NORM → IDLE next cycle, out_valid=0, in_ready=1.
